// File: rtl/mem_burst_tester_if.sv
// Burst request/data bus between the DDR3 self-test initiator and the memory controller.
interface mem_burst_tester_if #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24
);
    logic                     wr_burst_req;
    logic [9:0]               wr_burst_len;
    logic [ADDR_BITS-1:0]     wr_burst_addr;
    logic                     wr_burst_data_req;
    logic [MEM_DATA_BITS-1:0] wr_burst_data;
    logic                     wr_burst_finish;
    logic                     rd_burst_req;
    logic [9:0]               rd_burst_len;
    logic [ADDR_BITS-1:0]     rd_burst_addr;
    logic                     rd_burst_data_valid;
    logic [MEM_DATA_BITS-1:0] rd_burst_data;
    logic                     rd_burst_finish;

    // Initiator side (the tester)
    modport master (
        output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        output rd_burst_req, rd_burst_len, rd_burst_addr,
        input  wr_burst_data_req, wr_burst_finish,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    // Controller side
    modport slave (
        input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
        input  rd_burst_req, rd_burst_len, rd_burst_addr,
        output wr_burst_data_req, wr_burst_finish,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );
endinterface

// File: rtl/mem_burst_tester.sv
// DDR3 self-test engine: writes an address/pass-derived pattern over TEST_WORDS words
// in BURST_LEN bursts, reads it back, compares every beat and keeps error/pass counters.
// The pattern uses base[15:0], so ADDR_BITS is expected to be at least 16.
module mem_burst_tester #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int BURST_LEN     = 128,
    parameter int TEST_WORDS    = 4096
) (
    input  logic               mem_clk,
    input  logic               rst,
    input  logic               calib_done,
    mem_burst_tester_if.master bus,
    output logic               error,
    output logic               err_flag,
    output logic [15:0]        error_cnt,
    output logic [15:0]        pass_cnt
);
    localparam int                 REPS     = MEM_DATA_BITS / 16;
    localparam logic [9:0]         LEN      = 10'(BURST_LEN);
    localparam logic [ADDR_BITS:0] STEP     = (ADDR_BITS+1)'(BURST_LEN);
    localparam logic [ADDR_BITS:0] END_ADDR = (ADDR_BITS+1)'(TEST_WORDS);

    typedef enum logic [2:0] {IDLE, W_REQ, W_GAP, R_REQ, R_GAP} state_t;
    state_t state, state_nxt;

    logic                     calib_q;
    logic [ADDR_BITS:0]       base;      // one extra bit so it can hold TEST_WORDS
    logic [9:0]               beat;      // shared by write and read bursts
    logic [15:0]              word;
    logic [MEM_DATA_BITS-1:0] expect_data;
    logic                     wrap;
    logic                     wr_req;
    logic                     rd_req;
    logic                     beat_step;
    logic                     mismatch;

    assign word        = base[15:0] + 16'(beat);
    assign expect_data = {REPS{word ^ {pass_cnt[7:0], pass_cnt[7:0]}}};
    assign wrap        = (base == END_ADDR);
    assign beat_step   = (wr_req && bus.wr_burst_data_req) || (rd_req && bus.rd_burst_data_valid);
    assign mismatch    = rd_req && bus.rd_burst_data_valid && (bus.rd_burst_data != expect_data);

    assign bus.wr_burst_req  = wr_req;
    assign bus.rd_burst_req  = rd_req;
    assign bus.wr_burst_len  = LEN;
    assign bus.rd_burst_len  = LEN;
    assign bus.wr_burst_addr = wr_req ? base[ADDR_BITS-1:0] : '0;
    assign bus.rd_burst_addr = rd_req ? base[ADDR_BITS-1:0] : '0;
    assign bus.wr_burst_data = wr_req ? expect_data : '0;

    // State register
    always_ff @(posedge mem_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and request decode
    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        case (state)
            IDLE:  if (calib_q) state_nxt = W_REQ;
            W_REQ: begin
                wr_req = 1'b1;
                if (bus.wr_burst_finish) state_nxt = W_GAP;
            end
            W_GAP: state_nxt = wrap ? R_REQ : W_REQ;
            R_REQ: begin
                rd_req = 1'b1;
                if (bus.rd_burst_finish) state_nxt = R_GAP;
            end
            R_GAP: state_nxt = wrap ? W_REQ : R_REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered calib_done: start is taken from a clean flop, not straight off the controller
    always_ff @(posedge mem_clk) begin
        if (rst) calib_q <= 1'b0;
        else     calib_q <= calib_done;
    end

    // Beat counter: cleared outside bursts, saturates at BURST_LEN
    always_ff @(posedge mem_clk) begin
        if (rst || !(wr_req || rd_req)) beat <= '0;
        else if (beat_step && beat != LEN) beat <= beat + 10'd1;
    end

    // Burst base address: advance on finish, wrap to 0 in the gap after the last burst
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            base <= '0;
        end else begin
            case (state)
                IDLE:         base <= '0;
                W_REQ:        if (bus.wr_burst_finish) base <= base + STEP;
                R_REQ:        if (bus.rd_burst_finish) base <= base + STEP;
                W_GAP, R_GAP: if (wrap) base <= '0;
                default:      base <= base;
            endcase
        end
    end

    // Pass counter: one full write+read sweep completes in the final read gap
    always_ff @(posedge mem_clk) begin
        if (rst)                          pass_cnt <= '0;
        else if (state == R_GAP && wrap)  pass_cnt <= pass_cnt + 16'd1;
    end

    // Read-back checking: pulse, sticky flag and saturating mismatch count
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            error     <= 1'b0;
            err_flag  <= 1'b0;
            error_cnt <= '0;
        end else begin
            error <= mismatch;
            if (mismatch) begin
                err_flag <= 1'b1;
                if (error_cnt != 16'hFFFF) error_cnt <= error_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_burst_tester.sv
// Directed bench for mem_burst_tester with a small in-bench controller (BURST_LEN=4, TEST_WORDS=8).
module tb_mem_burst_tester;
    localparam int DW = 64;
    localparam int AW = 24;
    localparam int BL = 4;

    logic        mem_clk = 1'b0;
    logic        rst;
    logic        calib_done;
    logic        error;
    logic        err_flag;
    logic [15:0] error_cnt;
    logic [15:0] pass_cnt;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    mem_burst_tester_if #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    mem_burst_tester #(
        .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_LEN(BL), .TEST_WORDS(8)
    ) dut (
        .mem_clk(mem_clk), .rst(rst), .calib_done(calib_done), .bus(bus),
        .error(error), .err_flag(err_flag), .error_cnt(error_cnt), .pass_cnt(pass_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    function automatic logic [DW-1:0] pat(input int w, input int p);
        logic [15:0] h;
        logic [7:0]  pb;
        pb = p[7:0];
        h  = w[15:0] ^ {pb, pb};
        return {(DW/16){h}};
    endfunction

    task automatic wait_req(input bit rd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rd ? bus.rd_burst_req : bus.wr_burst_req) ok = 1'b1;
            else @(negedge mem_clk);
        end
    endtask

    task automatic serve_write(input int addr, input int p, input bit fin_last);
        bit ok;
        wait_req(1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_req_timeout addr=%0d", addr); end
        checks++;
        if (bus.wr_burst_addr !== AW'(addr) || bus.rd_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_addr got=%0d rd_req=%0b exp=%0d rd_req=0", bus.wr_burst_addr, bus.rd_burst_req, addr);
        end
        for (int b = 0; b < BL; b++) begin
            bus.wr_burst_data_req = 1'b1;
            if (fin_last && b == BL-1) bus.wr_burst_finish = 1'b1;
            checks++;
            if (bus.wr_burst_data !== pat(addr+b, p)) begin
                errors++;
                $display("FAIL wr_data w=%0d got=%h exp=%h", addr+b, bus.wr_burst_data, pat(addr+b, p));
            end
            @(negedge mem_clk);
        end
        bus.wr_burst_data_req = 1'b0;
        if (!fin_last) begin
            bus.wr_burst_finish = 1'b1;
            @(negedge mem_clk);
        end
        bus.wr_burst_finish = 1'b0;
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL wr_gap wr_req=%0b rd_req=%0b exp=0,0", bus.wr_burst_req, bus.rd_burst_req);
        end
    endtask

    // mode 0: correct data, 1: flip bit 0 of beat 2 of the burst at 0, 2: all-zero data
    task automatic serve_read(input int addr, input int p, input int mode);
        bit ok;
        logic [DW-1:0] d;
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rd_req_timeout addr=%0d", addr); end
        checks++;
        if (bus.rd_burst_addr !== AW'(addr) || bus.wr_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr got=%0d wr_req=%0b exp=%0d wr_req=0", bus.rd_burst_addr, bus.wr_burst_req, addr);
        end
        for (int b = 0; b < BL; b++) begin
            d = pat(addr+b, p);
            if (mode == 2) d = '0;
            else if (mode == 1 && addr == 0 && b == 2) d[0] = ~d[0];
            bus.rd_burst_data_valid = 1'b1;
            bus.rd_burst_data       = d;
            @(negedge mem_clk);
            if (error === 1'b1) pulses++;
        end
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish     = 1'b1;
        @(negedge mem_clk);
        bus.rd_burst_finish = 1'b0;
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0) begin
            errors++;
            $display("FAIL rd_gap wr_req=%0b rd_req=%0b exp=0,0", bus.wr_burst_req, bus.rd_burst_req);
        end
    endtask

    task automatic run_pass(input int p, input int mode);
        serve_write(0, p, 1'b0);
        serve_write(4, p, 1'b0);
        serve_read(0, p, mode);
        serve_read(4, p, mode);
        @(negedge mem_clk);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        calib_done = 1'b0;
        repeat (3) @(negedge mem_clk);
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0 || bus.wr_burst_addr !== '0 || bus.wr_burst_data !== '0) begin
            errors++;
            $display("FAIL reset_bus wr_req=%0b rd_req=%0b addr=%0d data=%h exp=all 0",
                     bus.wr_burst_req, bus.rd_burst_req, bus.wr_burst_addr, bus.wr_burst_data);
        end
        checks++;
        if (error !== 1'b0 || err_flag !== 1'b0 || error_cnt !== 16'd0 || pass_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stat error=%0b flag=%0b ecnt=%0d pcnt=%0d exp=0", error, err_flag, error_cnt, pass_cnt);
        end
        checks++;
        if (bus.wr_burst_len !== 10'd4 || bus.rd_burst_len !== 10'd4) begin
            errors++;
            $display("FAIL burst_len wr=%0d rd=%0d exp=4", bus.wr_burst_len, bus.rd_burst_len);
        end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge mem_clk);
            if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_hold req_cycles=%0d exp=0", bad); end
        calib_done = 1'b1;
        @(negedge mem_clk);
        checks++;
        if (bus.wr_burst_req !== 1'b0) begin errors++; $display("FAIL start_early wr_req=%0b exp=0", bus.wr_burst_req); end
        @(negedge mem_clk);
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.wr_burst_addr !== '0) begin
            errors++;
            $display("FAIL start wr_req=%0b addr=%0d exp=1 addr=0", bus.wr_burst_req, bus.wr_burst_addr);
        end
    endtask

    task automatic test_ideal_pass();
        pulses = 0;
        run_pass(0, 0);
        checks++;
        if (pass_cnt !== 16'd1 || error_cnt !== 16'd0 || err_flag !== 1'b0 || pulses != 0) begin
            errors++;
            $display("FAIL ideal_pass1 pcnt=%0d ecnt=%0d flag=%0b pulses=%0d exp=1,0,0,0", pass_cnt, error_cnt, err_flag, pulses);
        end
        run_pass(1, 0);
        checks++;
        if (pass_cnt !== 16'd2 || error_cnt !== 16'd0) begin
            errors++;
            $display("FAIL ideal_pass2 pcnt=%0d ecnt=%0d exp=2,0", pass_cnt, error_cnt);
        end
    endtask

    task automatic test_single_flip();
        pulses = 0;
        run_pass(2, 1);
        checks++;
        if (pulses != 1 || err_flag !== 1'b1 || error_cnt !== 16'd1 || pass_cnt !== 16'd3) begin
            errors++;
            $display("FAIL single_flip pulses=%0d flag=%0b ecnt=%0d pcnt=%0d exp=1,1,1,3", pulses, err_flag, error_cnt, pass_cnt);
        end
    endtask

    task automatic test_zero_data();
        pulses = 0;
        run_pass(3, 2);
        checks++;
        if (pulses != 8 || error_cnt !== 16'd9 || pass_cnt !== 16'd4) begin
            errors++;
            $display("FAIL zero_data pulses=%0d ecnt=%0d pcnt=%0d exp=8,9,4", pulses, error_cnt, pass_cnt);
        end
    endtask

    // Pass 4: one over-long all-zero read burst drives error_cnt 9 -> saturation
    task automatic test_saturation();
        bit ok;
        serve_write(0, 4, 1'b0);
        serve_write(4, 4, 1'b0);
        wait_req(1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_rd_timeout"); end
        bus.rd_burst_data_valid = 1'b1;
        bus.rd_burst_data       = '0;
        repeat (65525) @(negedge mem_clk);
        checks++;
        if (error_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_edge ecnt=%h exp=fffe", error_cnt); end
        repeat (5) @(negedge mem_clk);
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish     = 1'b1;
        @(negedge mem_clk);
        bus.rd_burst_finish = 1'b0;
        checks++;
        if (error_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit ecnt=%h exp=ffff", error_cnt); end
        serve_read(4, 4, 2);
        @(negedge mem_clk);
        checks++;
        if (error_cnt !== 16'hFFFF || pass_cnt !== 16'd5 || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold ecnt=%h pcnt=%0d flag=%0b exp=ffff,5,1", error_cnt, pass_cnt, err_flag);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        wait_req(1'b0, ok);
        bus.wr_burst_data_req = 1'b1;
        repeat (2) @(negedge mem_clk);
        bus.wr_burst_data_req = 1'b0;
        rst = 1'b1;
        @(negedge mem_clk);
        checks++;
        if (bus.wr_burst_req !== 1'b0 || bus.rd_burst_req !== 1'b0 || error_cnt !== 16'd0 || pass_cnt !== 16'd0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset wr_req=%0b rd_req=%0b ecnt=%0d pcnt=%0d flag=%0b exp=all 0",
                     bus.wr_burst_req, bus.rd_burst_req, error_cnt, pass_cnt, err_flag);
        end
        rst = 1'b0;
        wait_req(1'b0, ok);
        checks++;
        if (!ok || bus.wr_burst_addr !== '0 || bus.wr_burst_data !== pat(0, 0)) begin
            errors++;
            $display("FAIL restart ok=%0b addr=%0d data=%h exp=1 addr=0 data=0", ok, bus.wr_burst_addr, bus.wr_burst_data);
        end
    endtask

    task automatic test_back_to_back();
        serve_write(0, 0, 1'b1);
        @(negedge mem_clk);
        checks++;
        if (bus.wr_burst_req !== 1'b1 || bus.wr_burst_addr !== AW'(4)) begin
            errors++;
            $display("FAIL b2b_next wr_req=%0b addr=%0d exp=1 addr=4", bus.wr_burst_req, bus.wr_burst_addr);
        end
        serve_write(4, 0, 1'b1);
        @(negedge mem_clk);
        checks++;
        if (bus.rd_burst_req !== 1'b1 || bus.rd_burst_addr !== '0) begin
            errors++;
            $display("FAIL b2b_read rd_req=%0b addr=%0d exp=1 addr=0", bus.rd_burst_req, bus.rd_burst_addr);
        end
        pulses = 0;
        serve_read(0, 0, 0);
        serve_read(4, 0, 0);
        @(negedge mem_clk);
        checks++;
        if (pass_cnt !== 16'd1 || error_cnt !== 16'd0 || pulses != 0) begin
            errors++;
            $display("FAIL b2b_pass pcnt=%0d ecnt=%0d pulses=%0d exp=1,0,0", pass_cnt, error_cnt, pulses);
        end
    endtask

    initial begin
        rst                     = 1'b1;
        calib_done              = 1'b0;
        bus.wr_burst_data_req   = 1'b0;
        bus.wr_burst_finish     = 1'b0;
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_data       = '0;
        bus.rd_burst_finish     = 1'b0;
        test_reset();
        test_ideal_pass();
        test_single_flip();
        test_zero_data();
        test_saturation();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
